round_robin_arbiter: RTL and testbench



---
 rtl/round_robin_arbiter_pkg.sv | 19 +
 rtl/round_robin_arbiter_rr_pick4.sv | 28 ++
 rtl/round_robin_arbiter.sv | 119 +++++++++++
 tb/tb_round_robin_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM encodings, requester count and index/one-hot conversion.
package arb_defs;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01
    } state_e;

    localparam logic [NUM_REQ-1:0] ONEHOT_BASE = 4'b0001;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return ONEHOT_BASE << idx;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_rr_pick4.sv
// Rotating-priority selector: first requester at or after ptr (mod 4).
// Purely combinational; outputs carry the _c marker.
module rr_pick4
    import arb_defs::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr_i + IDX_W'(k);
            if (req_i[cand]) begin
                idx_c_o = cand;
                any_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter for four requesters with hold-while-requesting and
// quantum-based preemption; grant exported one-hot and as index + valid.
module round_robin_arbiter
    import arb_defs::*;
#(
    parameter int unsigned QUANTUM = 8,
    parameter int unsigned CW      = 8
) (
    input  logic               clock,
    input  logic               reset_b,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_id_o,
    output logic               gnt_valid_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]      hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   gnt_id_d;
    logic               gnt_valid_d;

    logic [NUM_REQ-1:0] others;
    logic [IDX_W-1:0]   pick_idx, mpick_idx, new_owner;
    logic               pick_any, mpick_any, grant_new;

    assign others = req_i & ~idx2onehot(owner_q);

    rr_pick4 u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .idx_c_o (pick_idx),
        .any_c_o (pick_any)
    );

    rr_pick4 u_pick_masked (
        .req_i   (others),
        .ptr_i   (ptr_q),
        .idx_c_o (mpick_idx),
        .any_c_o (mpick_any)
    );

    // Next-state: release takes precedence over quantum expiry.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        grant_new   = 1'b0;
        new_owner   = '0;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_new = 1'b1;
                    new_owner = pick_idx;
                end
            end
            ST_GRANT: begin
                if (!req_i[owner_q]) begin
                    if (pick_any) begin
                        grant_new = 1'b1;
                        new_owner = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end else if (hold_q >= CW'(QUANTUM) && mpick_any) begin
                    grant_new = 1'b1;
                    new_owner = mpick_idx;
                end else if (hold_q < CW'(QUANTUM)) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_new) begin
            state_d = ST_GRANT;
            owner_d = new_owner;
            ptr_d   = new_owner + IDX_W'(1);
            hold_d  = CW'(1);
        end

        if (state_d == ST_GRANT) begin
            gnt_d       = idx2onehot(owner_d);
            gnt_id_d    = owner_d;
            gnt_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            gnt_valid_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_o       <= gnt_d;
            gnt_id_o    <= gnt_id_d;
            gnt_valid_o <= gnt_valid_d;
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed scoreboard bench for round_robin_arbiter (QUANTUM=4):
// expected grants are queued as each request pattern is driven.
module tb_round_robin_arbiter;

    logic       clock;
    logic       reset_b;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int errors = 0;
    int checks = 0;
    logic [6:0] exp_q[$];

    round_robin_arbiter #(
        .QUANTUM (4),
        .CW      (8)
    ) dut (
        .clock       (clock),
        .reset_b     (reset_b),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] oh_to_idx(input logic [3:0] oh);
        case (oh)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s observed gnt/id/v=%b expected=%b", tag, obs, expv);
            $error("check %s failed", tag);
        end
    endtask

    // Drive one request pattern, queue the expected grant, compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input string tag);
        logic [6:0] e;
        req = r;
        exp_q.push_back({eg, oh_to_idx(eg), |eg});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check(tag, {gnt, gnt_id, gnt_valid}, e);
        @(negedge clock);
    endtask

    initial begin
        reset_b = 1'b0;
        req     = 4'b1111;
        #12;
        check("reset_hold", {gnt, gnt_id, gnt_valid}, 7'b0000_00_0);
        @(negedge clock);
        reset_b = 1'b1;

        // Rotation 0,1,2,3,0 with back-to-back transfers
        step(4'b1111, 4'b0001, "first_grant");
        step(4'b1111, 4'b0001, "rot0_hold");
        step(4'b1110, 4'b0010, "rot_to1");
        step(4'b1111, 4'b0010, "rot1_hold");
        step(4'b1101, 4'b0100, "rot_to2");
        step(4'b1111, 4'b0100, "rot2_hold");
        step(4'b1011, 4'b1000, "rot_to3");
        step(4'b1111, 4'b1000, "rot3_hold");
        step(4'b0111, 4'b0001, "rot_to0");
        step(4'b0000, 4'b0000, "rot_idle");

        // Preemption after exactly four cycles of ownership
        step(4'b0100, 4'b0100, "pre_c1");
        step(4'b0100, 4'b0100, "pre_c2");
        step(4'b0101, 4'b0100, "pre_c3");
        step(4'b0101, 4'b0100, "pre_c4");
        step(4'b0101, 4'b0001, "pre_move");
        step(4'b0000, 4'b0000, "pre_idle");

        // Sole requester is never preempted
        for (int i = 0; i < 22; i++) step(4'b0100, 4'b0100, "sole_hold");
        step(4'b0000, 4'b0000, "sole_idle");

        // Pointer priority: ptr=2 puts index 3 ahead of 0
        step(4'b0010, 4'b0010, "ptr_own1");
        step(4'b1011, 4'b0010, "ptr_hold1");
        step(4'b1001, 4'b1000, "ptr_pick3");

        // Release coinciding with quantum expiry goes idle
        step(4'b1000, 4'b1000, "sim_h2");
        step(4'b1000, 4'b1000, "sim_h3");
        step(4'b1000, 4'b1000, "sim_h4");
        step(4'b0000, 4'b0000, "sim_rel_exp");

        // New request in the release cycle is granted at that edge
        step(4'b0100, 4'b0100, "newreq_own2");
        step(4'b0100, 4'b0100, "newreq_hold");
        step(4'b0001, 4'b0001, "newreq_same_edge");

        // Asynchronous reset while index 1 owns the grant
        step(4'b0010, 4'b0010, "arst_own1");
        #2;
        reset_b = 1'b0;
        #1;
        check("arst_async_drop", {gnt, gnt_id, gnt_valid}, 7'b0000_00_0);
        @(negedge clock);
        reset_b = 1'b1;
        step(4'b0011, 4'b0001, "arst_ptr0");
        step(4'b0010, 4'b0010, "arst_next1");
        step(4'b0000, 4'b0000, "end_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
